// File: rtl/uart_rx_ctrl_if.sv
// Receive-FIFO output stream between uart_rx_ctrl and its consumer.
// The controller drives the head word and its valid flag, and the consumer returns ready.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX control layer: frame-boundary config update plus receive FIFO with overflow flag.
// Optional parity/stop error counters are enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned DEF_PRESCALE   = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        cfg_wr,
    input  logic [PRESCALE_WIDTH-1:0]   cfg_prescale,
    input  logic                        cfg_par_en,
    input  logic                        cfg_par_typ,
    output logic                        cfg_ack,
    output logic                        cfg_err,
    output logic [PRESCALE_WIDTH-1:0]   Prescale,
    output logic                        PAR_EN,
    output logic                        PAR_TYP,
    input  logic                        rx_busy,
    output logic                        rx_hold,
    input  logic                        data_valid,
    input  logic [DATA_WIDTH-1:0]       P_DATA,
    input  logic                        par_err,
    input  logic                        stp_err,
    uart_rx_ctrl_if.master              rx_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        ovf,
    input  logic                        ovf_clr
`ifdef UART_RX_ERR_CNT_EN
    ,
    input  logic                        err_cnt_clr,
    output logic [7:0]                  par_err_cnt,
    output logic [7:0]                  stp_err_cnt
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [PRESCALE_WIDTH-1:0] prescale;
        logic                      par_en;
        logic                      par_typ;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam cfg_t CFG_RST = '{prescale: PRESCALE_WIDTH'(DEF_PRESCALE),
                                 par_en:   1'b0,
                                 par_typ:  1'b0};

    // ------------------------------------------------------------------
    // Configuration FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    cfg_t   shadow_q, shadow_d;
    cfg_t   active_q;
    cfg_t   held_q, held_d;
    logic   held_vld_q, held_vld_d;
    logic   ack_d, err_d, hold_d, apply_c;
    cfg_t   live_c, req_c;
    logic   wr_c, legal_c;

    always_comb begin
        live_c = '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};
        // A fresh write supersedes one parked during APPLY
        req_c   = cfg_wr ? live_c : held_q;
        wr_c    = cfg_wr || held_vld_q;
        legal_c = (req_c.prescale == PRESCALE_WIDTH'(8))  ||
                  (req_c.prescale == PRESCALE_WIDTH'(16)) ||
                  (req_c.prescale == PRESCALE_WIDTH'(32));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        err_d      = 1'b0;
        apply_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_c) begin
                    held_vld_d = 1'b0;
                    if (legal_c) begin
                        shadow_d = req_c;
                        state_d  = PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PEND: begin
                // Any write this cycle postpones the apply by one cycle
                if (cfg_wr) begin
                    if (legal_c) begin
                        shadow_d = req_c;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!rx_busy) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                apply_c = 1'b1;
                state_d = IDLE;
                if (cfg_wr) begin
                    held_d     = live_c;
                    held_vld_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack_d  = (state_d == APPLY);
        hold_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow_q   <= CFG_RST;
            active_q   <= CFG_RST;
            held_q     <= CFG_RST;
            held_vld_q <= 1'b0;
            cfg_ack    <= 1'b0;
            cfg_err    <= 1'b0;
            rx_hold    <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            cfg_ack    <= ack_d;
            cfg_err    <= err_d;
            rx_hold    <= hold_d;
            if (apply_c) begin
                active_q <= shadow_q;
            end
        end
    end

    assign Prescale = active_q.prescale;
    assign PAR_EN   = active_q.par_en;
    assign PAR_TYP  = active_q.par_typ;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  full_c, pop_c, push_c, ovf_set_c;

    always_comb begin
        full_c    = (cnt_q == CW'(FIFO_DEPTH));
        pop_c     = (cnt_q != '0) && rx_out.out_ready;
        // When full, a simultaneous pop frees the slot the push needs
        push_c    = data_valid && (!full_c || pop_c);
        ovf_set_c = data_valid && full_c && !pop_c;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= P_DATA;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf <= 1'b0;
        end else if (ovf_set_c) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign rx_out.out_data  = mem_q[rd_ptr_q];
    assign rx_out.out_valid = (cnt_q != '0);
    assign fifo_cnt         = cnt_q;

    // ------------------------------------------------------------------
    // Optional receiver error counters
    // ------------------------------------------------------------------
`ifdef UART_RX_ERR_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            if (par_err && (par_err_cnt != 8'hFF)) begin
                par_err_cnt <= par_err_cnt + 8'd1;
            end
            if (stp_err && (stp_err_cnt != 8'hFF)) begin
                stp_err_cnt <= stp_err_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_err_c;
    assign unused_err_c = par_err | stp_err;
`endif

endmodule
